// File: rtl/range_ctrl.sv
// range_ctrl: ultrasonic ranging sequencer: trigger pulse, BCD echo timing and display digit latch.
module range_ctrl #(
    parameter int TRIG_CYCLES = 500,
    parameter int CM_DIV      = 29,
    parameter int PERIOD      = 3000000,
    parameter int TIMEOUT     = 1500000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Echo,
    output logic       Trig,
    output logic [3:0] Hundred,
    output logic [3:0] Ten,
    output logic [3:0] One,
    output logic [3:0] D_Ten,
    output logic [3:0] D_Hundred,
    output logic       Valid,
    output logic       Busy
);
    localparam int SW = $clog2((TRIG_CYCLES > TIMEOUT ? TRIG_CYCLES : TIMEOUT) + 1);
    localparam int PW = $clog2(PERIOD + TRIG_CYCLES + 2 * TIMEOUT + 1);
    localparam int DW = $clog2(CM_DIV + 1);
    localparam logic [SW-1:0] TRIG_LAST = SW'(TRIG_CYCLES - 1);
    localparam logic [SW-1:0] TMO_LAST  = SW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CM_DIV - 1);
    localparam logic [19:0]   ALL_NINE  = 20'h99999;

    typedef enum logic [1:0] {TRIG, WAIT, MEAS, HOLD} state_t;

    state_t        st, st_n;
    logic          run, carry, tick, load, tmo, echo_s, rise, fall;
    logic [2:0]    sync;
    logic [SW-1:0] st_cnt;
    logic [PW-1:0] per_cnt;
    logic [DW-1:0] pre;
    logic [19:0]   acc, acc_inc, dig;

    // run holds the sequencer idle for the cycle in which RST is released
    assign echo_s = sync[1];
    assign rise   = sync[1] & ~sync[2];
    assign fall   = ~sync[1] & sync[2];
    assign tick   = st == MEAS && echo_s && pre == DIV_LAST;
    assign Trig   = run && st == TRIG;
    assign Busy   = run && st != HOLD;
    assign {Hundred, Ten, One, D_Ten, D_Hundred} = dig;

    always_comb begin
        acc_inc = acc;
        carry = 1'b1;
        for (int i = 0; i < 5; i++) begin
            acc_inc[4*i +: 4] = carry ? (acc[4*i +: 4] == 4'd9 ? 4'd0 : acc[4*i +: 4] + 4'd1) : acc[4*i +: 4];
            carry = carry && acc[4*i +: 4] == 4'd9;
        end
    end

    // a falling edge is tested before the timeout so it wins a tie
    always_comb begin
        st_n = st;
        load = 1'b0;
        tmo  = 1'b0;
        if (run)
            case (st)
                TRIG: st_n = st_cnt == TRIG_LAST ? WAIT : TRIG;
                WAIT: begin
                    st_n = rise ? MEAS : st_cnt == TMO_LAST ? HOLD : WAIT;
                    tmo  = !rise && st_cnt == TMO_LAST;
                end
                MEAS: begin
                    st_n = fall || st_cnt == TMO_LAST ? HOLD : MEAS;
                    load = fall;
                    tmo  = !fall && st_cnt == TMO_LAST;
                end
                HOLD: st_n = per_cnt >= PER_LAST ? TRIG : HOLD;
            endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            st      <= TRIG;
            run     <= 1'b0;
            sync    <= '0;
            st_cnt  <= '0;
            per_cnt <= '0;
            pre     <= '0;
            acc     <= '0;
            dig     <= '0;
            Valid   <= 1'b0;
        end else begin
            run     <= 1'b1;
            sync    <= {sync[1:0], Echo};
            st      <= st_n;
            st_cnt  <= st_n != st ? '0 : st_cnt + SW'(run);
            per_cnt <= st == HOLD && st_n == TRIG ? '0 : per_cnt + PW'(run);
            if (st == TRIG) begin
                pre <= '0;
                acc <= '0;
            end else if (st == MEAS && echo_s) begin
                pre <= tick ? '0 : pre + DW'(1);
                if (tick && acc != ALL_NINE)
                    acc <= acc_inc;
            end
            if (load) begin
                dig   <= acc;
                Valid <= 1'b1;
            end else if (tmo) begin
                dig   <= ALL_NINE;
                Valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/range_ctrl.md
Name: range_ctrl

Overview:
- Sequencing controller for one ultrasonic ranging cycle: fires the sensor trigger pulse, times the echo pulse and produces the five BCD digits consumed by the seven-segment display multiplexer (Hundred, Ten, One, D_Ten, D_Hundred = ddd.dd cm).
- Echo time is counted directly in BCD at a prescaled tick equal to 0.01 cm of range, so no divider or binary-to-BCD stage is required.
- Sits between the sensor pins and the display block; display digits change only at the end of a measurement.

Parameters:
- TRIG_CYCLES, 500: Trig high width in CLK cycles (10 us at 50 MHz).
- CM_DIV, 29: CLK cycles per 0.01 cm of range, i.e. per 0.583 us of round trip. Legal range is 1 or more.
- PERIOD, 3000000: CLK cycles from one trigger start to the next (60 ms).
- TIMEOUT, 1500000: maximum cycles spent in WAIT, and separately in MEAS.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- Echo  in  1  asynchronous sensor echo pin
- Trig  out  1  sensor trigger pulse
- Hundred  out  4  BCD hundreds of cm
- Ten  out  4  BCD tens of cm
- One  out  4  BCD units of cm
- D_Ten  out  4  BCD 0.1 cm
- D_Hundred  out  4  BCD 0.01 cm
- Valid  out  1  1 = digits hold a good measurement; 0 = timeout or no measurement yet
- Busy  out  1  1 while in TRIG, WAIT or MEAS

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high (RST), sampled on posedge CLK.
- Reset values:
  - All digits 0, Trig 0, Valid 0, Busy 0.
  - Synchroniser cleared, BCD accumulator 0, prescaler 0, period counter 0.
  - State = TRIG, entered on the first cycle after RST deasserts.
- Echo synchroniser: two flops produce echo_s, and a third flop feeds the rising/falling-edge detect. Pin-to-echo_s latency is 2 cycles.
- Period counter: cleared on entry to TRIG, increments every cycle. The next TRIG begins exactly PERIOD cycles after the previous TRIG began.
- State TRIG:
  - Trig = 1 for exactly TRIG_CYCLES cycles.
  - BCD accumulator and prescaler cleared.
  - Then go to WAIT.
- State WAIT:
  - Waits for a rising edge of echo_s; on it, go to MEAS.
  - An echo already high on entry is not a rising edge, so it is ignored.
  - After TIMEOUT cycles in WAIT with no rising edge, take the timeout action.
- State MEAS:
  - The prescaler counts 0..CM_DIV-1 on each cycle echo_s is high; at CM_DIV-1 it wraps and the accumulator increments by 1.
  - Result is floor(N/CM_DIV), where N = number of echo_s-high cycles in MEAS.
  - Accumulator is 5-digit cascaded BCD: each digit wraps 9 to 0 with carry. It saturates at 999.99 and does not wrap to 000.00.
  - On the falling edge of echo_s: on the next cycle load the accumulator into the outputs, Valid = 1, go to HOLD.
  - After TIMEOUT cycles in MEAS, take the timeout action.
- Timeout action: all digits = 9, Valid = 0, go to HOLD.
- State HOLD: Busy = 0. When the period counter reaches PERIOD-1, go to TRIG.
- Output registers change only at a load or timeout. Intermediate accumulator values never reach the outputs.
- Simultaneous events:
  - Falling edge and timeout in the same cycle: the falling edge wins (good result).
  - Period expiry while still in WAIT or MEAS: the current measurement completes; TRIG then starts on the cycle after HOLD is entered.
- Reset during any state returns everything to reset values. Reset does not wait for echo to finish.

Test Plan:
1. Reset, then release (TRIG_CYCLES=4, CM_DIV=3, PERIOD=8000, TIMEOUT=4000) -> Trig high for cycles 1..4 after release; all digits 0, Valid 0, Busy 1.
2. Echo pulse giving N=369 echo_s-high cycles -> digits 0,0,1,2,3 (001.23); Valid 1 one cycle after the echo_s falling edge; Busy 0.
3. Echo pulse giving N=300 -> 001.00, which checks the D_Hundred/D_Ten ripple carry; a second period with N=30 -> 000.10, confirming the accumulator cleared in TRIG.
4. Echo never rises -> exactly 4000 cycles after WAIT entry, digits 9,9,9,9,9 and Valid 0; next Trig starts at cycle 8000 of the period.
5. Echo held high before and through TRIG (stuck high) -> no MEAS entry; timeout result 999.99 with Valid 0. With CM_DIV=1, TIMEOUT=200000 and a 100005-cycle echo -> output saturates at 999.99 with Valid 1.
6. RST asserted for 1 cycle in mid-MEAS -> next cycle all digits 0, Trig 0, Valid 0; Trig restarts on the following cycle.
